// File: rtl/noc2node_response_filter.sv
// noc2node_response_filter
// Filters NoC responses against a pending-transaction table: each accepted
// response is looked up once with a swapped sender/recipient key. A hit
// deletes the table entry and forwards the response to the node. A miss
// drops the response and pulses unmatched_o.
// Optional feature macro: RESP_FILTER_UNMATCHED_CNT_EN builds a saturating
// counter of dropped responses on unmatched_count_o. When the macro is not
// defined, unmatched_count_o is tied to zero.

`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif
`ifndef N_BITS_COHERENCE_MESSAGE_TYPE
`define N_BITS_COHERENCE_MESSAGE_TYPE 4
`endif

module noc2node_response_filter #(
  parameter int unsigned BUS_ADDRESS_WIDTH = `BUS_ADDRESS_WIDTH,
  parameter int unsigned N_BITS_TYPE       = `N_BITS_COHERENCE_MESSAGE_TYPE,
  parameter int unsigned PAYLOAD_WIDTH     = 64,
  parameter int unsigned CNT_WIDTH         = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         msg_valid_i,
  output logic                         msg_ready_o,
  input  logic [BUS_ADDRESS_WIDTH-1:0] msg_sender_i,
  input  logic [BUS_ADDRESS_WIDTH-1:0] msg_recipient_i,
  input  logic [N_BITS_TYPE-1:0]       msg_type_i,
  input  logic [PAYLOAD_WIDTH-1:0]     msg_payload_i,
  output logic                         query_o,
  output logic [BUS_ADDRESS_WIDTH-1:0] query_sender_o,
  output logic [BUS_ADDRESS_WIDTH-1:0] query_recipient_o,
  output logic [N_BITS_TYPE-1:0]       query_transaction_type_o,
  output logic                         delete_transaction_o,
  input  logic                         is_a_pending_transaction_i,
  output logic                         node_valid_o,
  input  logic                         node_ready_i,
  output logic [BUS_ADDRESS_WIDTH-1:0] node_sender_o,
  output logic [BUS_ADDRESS_WIDTH-1:0] node_recipient_o,
  output logic [N_BITS_TYPE-1:0]       node_type_o,
  output logic [PAYLOAD_WIDTH-1:0]     node_payload_o,
  output logic                         unmatched_o,
  output logic [CNT_WIDTH-1:0]         unmatched_count_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FWD    = 2'd2
  } state_t;

  state_t                       state_q;
  logic [BUS_ADDRESS_WIDTH-1:0] sender_q;
  logic [BUS_ADDRESS_WIDTH-1:0] recipient_q;
  logic [N_BITS_TYPE-1:0]       type_q;
  logic [PAYLOAD_WIDTH-1:0]     payload_q;

  logic in_idle;
  logic in_lookup;
  logic in_fwd;

  assign in_idle   = (state_q == IDLE);
  assign in_lookup = (state_q == LOOKUP);
  assign in_fwd    = (state_q == FWD);

  // The state already reads IDLE while reset is held, so ready is also
  // gated by rst to keep the upstream from seeing an accept during reset.
  assign msg_ready_o = in_idle & ~rst;

  assign query_o                  = in_lookup;
  assign query_sender_o           = recipient_q;
  assign query_recipient_o        = sender_q;
  assign query_transaction_type_o = type_q;
  assign delete_transaction_o     = in_lookup & is_a_pending_transaction_i;
  assign unmatched_o              = in_lookup & ~is_a_pending_transaction_i;

  assign node_valid_o     = in_fwd;
  assign node_sender_o    = sender_q;
  assign node_recipient_o = recipient_q;
  assign node_type_o      = type_q;
  assign node_payload_o   = payload_q;

  // Control FSM and holding register: capture in IDLE, one lookup cycle,
  // then hold the response in FWD until the node takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sender_q    <= '0;
      recipient_q <= '0;
      type_q      <= '0;
      payload_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (msg_valid_i) begin
            sender_q    <= msg_sender_i;
            recipient_q <= msg_recipient_i;
            type_q      <= msg_type_i;
            payload_q   <= msg_payload_i;
            state_q     <= LOOKUP;
          end
        end
        LOOKUP: begin
          state_q <= is_a_pending_transaction_i ? FWD : IDLE;
        end
        FWD: begin
          if (node_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef RESP_FILTER_UNMATCHED_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Next count: step on every dropped response, hold at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (unmatched_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign unmatched_count_o = cnt_q;
`else
  assign unmatched_count_o = '0;
`endif

endmodule

// File: tb/tb_noc2node_response_filter.sv
// Self-checking bench for noc2node_response_filter. Models the pending
// table as a small array and predicts each response's outcome from the
// table contents at transaction level.
`timescale 1ns/1ps

module tb_noc2node_response_filter;

  localparam int unsigned AW  = 4;
  localparam int unsigned TW  = 3;
  localparam int unsigned PW  = 16;
  localparam int unsigned CW  = 2;
  localparam int unsigned TBL = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          msg_valid_i = 1'b0;
  logic          msg_ready_o;
  logic [AW-1:0] msg_sender_i = '0;
  logic [AW-1:0] msg_recipient_i = '0;
  logic [TW-1:0] msg_type_i = '0;
  logic [PW-1:0] msg_payload_i = '0;
  logic          query_o;
  logic [AW-1:0] query_sender_o;
  logic [AW-1:0] query_recipient_o;
  logic [TW-1:0] query_transaction_type_o;
  logic          delete_transaction_o;
  logic          is_a_pending_transaction_i;
  logic          node_valid_o;
  logic          node_ready_i = 1'b0;
  logic [AW-1:0] node_sender_o;
  logic [AW-1:0] node_recipient_o;
  logic [TW-1:0] node_type_o;
  logic [PW-1:0] node_payload_o;
  logic          unmatched_o;
  logic [CW-1:0] unmatched_count_o;

  // Pending-transaction table, stored as the query key (sender, recipient, type).
  logic          tbl_v [TBL];
  logic [AW-1:0] tbl_s [TBL];
  logic [AW-1:0] tbl_r [TBL];
  logic [TW-1:0] tbl_t [TBL];

  int n_cmp = 0;
  int n_err = 0;
  int n_miss = 0;

  noc2node_response_filter #(
    .BUS_ADDRESS_WIDTH(AW),
    .N_BITS_TYPE(TW),
    .PAYLOAD_WIDTH(PW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .msg_valid_i(msg_valid_i),
    .msg_ready_o(msg_ready_o),
    .msg_sender_i(msg_sender_i),
    .msg_recipient_i(msg_recipient_i),
    .msg_type_i(msg_type_i),
    .msg_payload_i(msg_payload_i),
    .query_o(query_o),
    .query_sender_o(query_sender_o),
    .query_recipient_o(query_recipient_o),
    .query_transaction_type_o(query_transaction_type_o),
    .delete_transaction_o(delete_transaction_o),
    .is_a_pending_transaction_i(is_a_pending_transaction_i),
    .node_valid_o(node_valid_o),
    .node_ready_i(node_ready_i),
    .node_sender_o(node_sender_o),
    .node_recipient_o(node_recipient_o),
    .node_type_o(node_type_o),
    .node_payload_o(node_payload_o),
    .unmatched_o(unmatched_o),
    .unmatched_count_o(unmatched_count_o)
  );

  always #5 clk = ~clk;

  // Table lookup answers combinationally in the query cycle.
  always_comb begin
    is_a_pending_transaction_i = 1'b0;
    for (int i = 0; i < TBL; i++) begin
      if (tbl_v[i] && tbl_s[i] == query_sender_o && tbl_r[i] == query_recipient_o &&
          tbl_t[i] == query_transaction_type_o) begin
        is_a_pending_transaction_i = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_count();
`ifdef RESP_FILTER_UNMATCHED_CNT_EN
    return (n_miss > 3) ? 64'd3 : 64'(n_miss);
`else
    return 64'd0;
`endif
  endfunction

  task automatic tbl_clear();
    for (int i = 0; i < TBL; i++) begin
      tbl_v[i] = 1'b0; tbl_s[i] = '0; tbl_r[i] = '0; tbl_t[i] = '0;
    end
  endtask

  task automatic tbl_put(input int idx, input logic [AW-1:0] s, input logic [AW-1:0] r,
                         input logic [TW-1:0] t);
    tbl_v[idx] = 1'b1; tbl_s[idx] = s; tbl_r[idx] = r; tbl_t[idx] = t;
  endtask

  // One complete response: predicts hit/miss from the table, checks the
  // lookup cycle, any stall cycles in FWD and the return to IDLE.
  task automatic send(input logic [AW-1:0] s, input logic [AW-1:0] r, input logic [TW-1:0] t,
                      input logic [PW-1:0] p, input int unsigned stall);
    bit exp_hit;
    int idx;
    exp_hit = 1'b0;
    idx = -1;
    for (int i = 0; i < TBL; i++) begin
      if (!exp_hit && tbl_v[i] && tbl_s[i] == r && tbl_r[i] == s && tbl_t[i] == t) begin
        exp_hit = 1'b1;
        idx = i;
      end
    end
    check("ready_idle", 64'(msg_ready_o), 64'd1);
    msg_valid_i = 1'b1; msg_sender_i = s; msg_recipient_i = r; msg_type_i = t; msg_payload_i = p;
    step();
    msg_valid_i = 1'b0;
    msg_sender_i = AW'($urandom); msg_recipient_i = AW'($urandom);
    msg_type_i = TW'($urandom); msg_payload_i = PW'($urandom);
    check("lk_query", 64'(query_o), 64'd1);
    check("lk_qsender", 64'(query_sender_o), 64'(r));
    check("lk_qrecip", 64'(query_recipient_o), 64'(s));
    check("lk_qtype", 64'(query_transaction_type_o), 64'(t));
    check("lk_delete", 64'(delete_transaction_o), 64'(exp_hit));
    check("lk_unmatched", 64'(unmatched_o), 64'(!exp_hit));
    check("lk_ready", 64'(msg_ready_o), 64'd0);
    check("lk_nvalid", 64'(node_valid_o), 64'd0);
    step();
    if (exp_hit) begin
      tbl_v[idx] = 1'b0;
      for (int k = 0; k < int'(stall); k++) begin
        check("st_nvalid", 64'(node_valid_o), 64'd1);
        check("st_payload", 64'(node_payload_o), 64'(p));
        check("st_sender", 64'(node_sender_o), 64'(s));
        check("st_recip", 64'(node_recipient_o), 64'(r));
        check("st_type", 64'(node_type_o), 64'(t));
        check("st_ready", 64'(msg_ready_o), 64'd0);
        check("st_query", 64'(query_o), 64'd0);
        step();
      end
      node_ready_i = 1'b1;
      check("fw_nvalid", 64'(node_valid_o), 64'd1);
      check("fw_payload", 64'(node_payload_o), 64'(p));
      check("fw_sender", 64'(node_sender_o), 64'(s));
      check("fw_delete", 64'(delete_transaction_o), 64'd0);
      step();
      node_ready_i = 1'b0;
    end else begin
      n_miss++;
    end
    check("end_nvalid", 64'(node_valid_o), 64'd0);
    check("end_ready", 64'(msg_ready_o), 64'd1);
    check("end_unmatched", 64'(unmatched_o), 64'd0);
    check("end_count", 64'(unmatched_count_o), exp_count());
  endtask

  initial begin
    int dels;
    tbl_clear();
    // Reset state, asynchronously visible before any clock edge.
    #1;
    check("rst_ready", 64'(msg_ready_o), 64'd0);
    check("rst_nvalid", 64'(node_valid_o), 64'd0);
    check("rst_query", 64'(query_o), 64'd0);
    check("rst_count", 64'(unmatched_count_o), 64'd0);
    step(); step();
    rst = 1'b0;
    step();
    check("post_rst_ready", 64'(msg_ready_o), 64'd1);

    // Directed hit, then miss, then backpressured hit.
    tbl_put(0, 4'd1, 4'd2, 3'd0);
    send(4'd2, 4'd1, 3'd0, 16'hCAFE, 0);
    send(4'd3, 4'd1, 3'd0, 16'h1234, 0);
    tbl_put(1, 4'd7, 4'd9, 3'd5);
    send(4'd9, 4'd7, 3'd5, 16'hA5A5, 5);

    // Back-to-back hits with valid held high and ready high.
    tbl_clear();
    tbl_put(0, 4'd1, 4'd2, 3'd0);
    tbl_put(1, 4'd5, 4'd6, 3'd1);
    node_ready_i = 1'b1;
    dels = 0;
    msg_valid_i = 1'b1; msg_sender_i = 4'd2; msg_recipient_i = 4'd1; msg_type_i = 3'd0;
    msg_payload_i = 16'hCAFE;
    step();
    msg_sender_i = 4'd6; msg_recipient_i = 4'd5; msg_type_i = 3'd1; msg_payload_i = 16'hBEEF;
    dels += int'(delete_transaction_o);
    check("b2b_q1", 64'(query_sender_o), 64'd1);
    check("b2b_rdy1", 64'(msg_ready_o), 64'd0);
    step();
    tbl_v[0] = 1'b0;
    dels += int'(delete_transaction_o);
    check("b2b_nv1", 64'(node_valid_o), 64'd1);
    check("b2b_p1", 64'(node_payload_o), 64'hCAFE);
    check("b2b_rdy2", 64'(msg_ready_o), 64'd0);
    step();
    dels += int'(delete_transaction_o);
    check("b2b_rdy3", 64'(msg_ready_o), 64'd1);
    step();
    msg_valid_i = 1'b0;
    dels += int'(delete_transaction_o);
    check("b2b_q2", 64'(query_sender_o), 64'd5);
    check("b2b_query2", 64'(query_o), 64'd1);
    step();
    tbl_v[1] = 1'b0;
    dels += int'(delete_transaction_o);
    check("b2b_p2", 64'(node_payload_o), 64'hBEEF);
    step();
    dels += int'(delete_transaction_o);
    check("b2b_deletes", 64'(dels), 64'd2);
    node_ready_i = 1'b0;

    // Saturation: five misses from a cleared count.
    tbl_clear();
    rst = 1'b1; #1; rst = 1'b0; n_miss = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      send(AW'(i), 4'd15, 3'd2, PW'(i), 0);
    end
    check("sat_count", 64'(unmatched_count_o), exp_count());

    // Reset while forwarding.
    tbl_put(0, 4'd1, 4'd2, 3'd0);
    msg_valid_i = 1'b1; msg_sender_i = 4'd2; msg_recipient_i = 4'd1; msg_type_i = 3'd0;
    msg_payload_i = 16'h5555;
    step();
    msg_valid_i = 1'b0;
    step();
    tbl_v[0] = 1'b0;
    check("rf_nvalid_pre", 64'(node_valid_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rf_nvalid", 64'(node_valid_o), 64'd0);
    check("rf_ready", 64'(msg_ready_o), 64'd0);
    check("rf_delete", 64'(delete_transaction_o), 64'd0);
    check("rf_count", 64'(unmatched_count_o), 64'd0);
    n_miss = 0;
    step(); step();
    rst = 1'b0;
    step();
    check("rf_ready_after", 64'(msg_ready_o), 64'd1);
    check("rf_nvalid_after", 64'(node_valid_o), 64'd0);

    // Randomized traffic against the table model.
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] s, r;
      logic [TW-1:0] t;
      int pick;
      if ($urandom_range(1, 0) == 1) begin
        tbl_put(int'($urandom_range(TBL - 1, 0)), AW'($urandom), AW'($urandom), TW'($urandom));
      end
      s = AW'($urandom); r = AW'($urandom); t = TW'($urandom);
      pick = int'($urandom_range(TBL - 1, 0));
      if ($urandom_range(2, 0) != 0 && tbl_v[pick]) begin
        s = tbl_r[pick]; r = tbl_s[pick]; t = tbl_t[pick];
      end
      send(s, r, t, PW'($urandom), $urandom_range(3, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/noc2node_response_filter.md
NOC2NODE_RESPONSE_FILTER -- requirements
Module: noc2node_response_filter

Interface
REQ-001 SHALL have parameter BUS_ADDRESS_WIDTH, default `BUS_ADDRESS_WIDTH, width of the sender and recipient fields.
REQ-002 SHALL have parameter N_BITS_TYPE, default `N_BITS_COHERENCE_MESSAGE_TYPE, width of the message type field.
REQ-003 SHALL have parameter PAYLOAD_WIDTH, default 64, width of the response payload.
REQ-004 SHALL have parameter CNT_WIDTH, default 8, width of the unmatched-response counter.
REQ-005 SHALL use one clock and an asynchronous, active-high reset, with ports named as below.
REQ-006 clk  in  1  clock; all state updates on posedge.
REQ-007 rst  in  1  asynchronous reset, active-high.
REQ-008 msg_valid_i  in  1  a response from the NoC is present.
REQ-009 msg_ready_o  out  1  the block accepts a response.
REQ-010 msg_sender_i / msg_recipient_i  in  BUS_ADDRESS_WIDTH each  source and destination of the response.
REQ-011 msg_type_i  in  N_BITS_TYPE  response type; msg_payload_i  in  PAYLOAD_WIDTH  response data.
REQ-012 query_o  out  1  lookup strobe to the pending-transaction table.
REQ-013 query_sender_o / query_recipient_o  out  BUS_ADDRESS_WIDTH  lookup key; query_transaction_type_o  out  N_BITS_TYPE.
REQ-014 delete_transaction_o  out  1  removes the matched table entry.
REQ-015 is_a_pending_transaction_i  in  1  table hit, combinational in the query cycle.
REQ-016 node_valid_o  out  1 and node_ready_i  in  1  form the handshake toward the node.
REQ-017 node_sender_o, node_recipient_o, node_type_o, node_payload_o  out  carry the forwarded response.
REQ-018 unmatched_o  out  1  one-cycle pulse when a response is dropped; unmatched_count_o  out  CNT_WIDTH.

Function
REQ-019 SHALL implement the FSM states IDLE, LOOKUP and FWD.
REQ-020 In IDLE, msg_ready_o SHALL be 1; on msg_valid_i&msg_ready_o at a clock edge, the block SHALL capture all msg_* fields into a holding register and go to LOOKUP.
REQ-021 In every state except IDLE, msg_ready_o SHALL be 0.
REQ-022 In LOOKUP, query_o SHALL be 1 for exactly one cycle.
REQ-023 The lookup key SHALL be swapped: query_sender_o=captured recipient, query_recipient_o=captured sender, query_transaction_type_o=captured type.
REQ-024 In LOOKUP, delete_transaction_o SHALL equal is_a_pending_transaction_i; it SHALL be 0 in every other state.
REQ-025 On a LOOKUP hit, the next state SHALL be FWD.
REQ-026 On a LOOKUP miss, unmatched_o SHALL be 1 in that cycle, the next state SHALL be IDLE, and the response SHALL be discarded.
REQ-027 In FWD, node_valid_o SHALL be 1 and node_* SHALL show the captured fields unchanged.
REQ-028 The block SHALL stay in FWD until node_valid_o&node_ready_i, then go to IDLE.
REQ-029 Latency SHALL be: accept edge N; LOOKUP during cycle N+1; node_valid_o from cycle N+2.
REQ-030 Minimum spacing between accepted responses SHALL be 3 cycles for a hit with ready held high, and 2 cycles for a miss.
REQ-031 node_ready_i held low SHALL stall the block in FWD indefinitely with node_* stable; no new response is accepted meanwhile.
REQ-032 A response accepted in LOOKUP or FWD SHALL be impossible, because msg_ready_o=0 there.
REQ-033 query_o, delete_transaction_o, node_valid_o and unmatched_o SHALL be 0 outside their stated states.

Reset
REQ-034 rst asserted SHALL force state=IDLE, node_valid_o=0, query_o=0, delete_transaction_o=0, unmatched_o=0, unmatched_count_o=0 and the holding register=0 immediately, without a clock.
REQ-035 Reset mid-LOOKUP or mid-FWD SHALL discard the captured response, issue no delete and emit no node_valid_o.
REQ-036 While rst=1, msg_ready_o SHALL be 0; it SHALL be 1 from the first cycle after rst is released.

Configuration
REQ-037 Macro RESP_FILTER_UNMATCHED_CNT_EN defined: unmatched_count_o SHALL increment on each unmatched_o pulse and saturate at 2^CNT_WIDTH-1.
REQ-038 Macro RESP_FILTER_UNMATCHED_CNT_EN undefined: unmatched_count_o SHALL be tied to 0, no counter is built, and unmatched_o is unaffected.

Verification
REQ-039 Hit: table holds (1,2,0); send sender=2 recipient=1 type=0 payload=0xCAFE -> query (1,2,0) one cycle later with delete=1, node_valid_o two cycles after acceptance, node_payload_o=0xCAFE.
REQ-040 Miss: table empty; send sender=3 recipient=1 type=0 -> query_o=1, delete=0, unmatched_o pulse, node_valid_o stays 0, count=1 (macro on).
REQ-041 Backpressure: hit with node_ready_i=0 for 5 cycles -> node_valid_o=1 and fields stable for 5 cycles, msg_ready_o=0, then IDLE one cycle after ready rises.
REQ-042 Back-to-back: msg_valid_i held high with two hits -> second accepted exactly 3 cycles after the first; exactly 2 deletes.
REQ-043 Reset in FWD: assert rst while node_valid_o=1 -> node_valid_o drops without a clock; msg_ready_o=1 the cycle after release.
REQ-044 Saturation: CNT_WIDTH=2, 5 misses -> unmatched_count_o=3 with the macro defined; 0 with it undefined.
